// File: rtl/jk_pd_pkg.sv
// Shared constants for the multi-channel JK phase detector.
// The JK encodings match the {jx,kx} concatenation used by each channel.
package jk_pd_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_pd_channel.sv
// One detector channel: optional edge qualification of J/K, JK state register,
// and a saturating high-time counter that publishes a sample when Q falls.
module jk_pd_channel
  import jk_pd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_i,
  input  logic             j_i,
  input  logic             k_i,
  output logic             out_o,
  output logic [CNT_W-1:0] err_data_o,
  output logic             err_valid_o,
  output logic             err_sat_o
);

  logic             j_prev_q, k_prev_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_data_q, err_data_d;
  logic             err_sat_q, err_sat_d;
  logic             err_valid_q, err_valid_d;
  logic             jx, kx;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             carry;
  logic             fall;

  // History is tracked in both modes so switching to edge mode cannot fake an edge.
  always_comb begin
    jx = j_i;
    kx = k_i;
    if (mode_i == MODE_EDGE) begin
      jx = j_i & ~j_prev_q;
      kx = k_i & ~k_prev_q;
    end
  end

  always_comb begin
    out_d = out_q;
    case ({jx, kx})
      JK_HOLD:   out_d = out_q;
      JK_RESET:  out_d = 1'b0;
      JK_SET:    out_d = 1'b1;
      JK_TOGGLE: out_d = ~out_q;
      default:   out_d = out_q;
    endcase
  end

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign carry   = cnt_inc[CNT_W];
  assign cnt_sat = carry ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
  assign fall    = out_q & ~out_d;

  always_comb begin
    cnt_d       = '0;
    err_data_d  = err_data_q;
    err_sat_d   = err_sat_q;
    err_valid_d = 1'b0;
    if (out_q && out_d) begin
      cnt_d = cnt_sat;
    end
    if (fall) begin
      err_data_d  = cnt_sat;
      err_sat_d   = carry;
      err_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      j_prev_q    <= 1'b0;
      k_prev_q    <= 1'b0;
      out_q       <= 1'b0;
      cnt_q       <= '0;
      err_data_q  <= '0;
      err_sat_q   <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      j_prev_q    <= j_i;
      k_prev_q    <= k_i;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      err_data_q  <= err_data_d;
      err_sat_q   <= err_sat_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign out_o       = out_q;
  assign err_data_o  = err_data_q;
  assign err_sat_o   = err_sat_q;
  assign err_valid_o = err_valid_q;

endmodule

// File: rtl/jk_phase_detector.sv
// Multi-channel JK phase detector: CHANNELS independent channels sharing one mode select,
// with per-channel phase-error samples packed into err_data.
module jk_phase_detector
  import jk_pd_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       j,
  input  logic [CHANNELS-1:0]       k,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       out_n,
  output logic [CHANNELS*CNT_W-1:0] err_data,
  output logic [CHANNELS-1:0]       err_valid,
  output logic [CHANNELS-1:0]       err_sat
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    jk_pd_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .mode_i      (mode),
      .j_i         (j[c]),
      .k_i         (k[c]),
      .out_o       (out[c]),
      .err_data_o  (err_data[c*CNT_W +: CNT_W]),
      .err_valid_o (err_valid[c]),
      .err_sat_o   (err_sat[c])
    );
  end

  assign out_n = ~out;

endmodule

// File: tb/tb_jk_phase_detector.sv
// Bench for jk_phase_detector: two instances (CNT_W=8 and CNT_W=4) share stimulus; a behavioural
// model predicts Q each cycle and queues expected samples that are popped when err_valid pulses.
module tb_jk_phase_detector;

  localparam int CH = 4;

  logic clk;
  logic reset;
  logic mode;
  logic [CH-1:0] j, k;

  logic [CH-1:0]   o8_out, o8_outn, o8_vld, o8_sat;
  logic [CH*8-1:0] o8_dat;
  logic [CH-1:0]   o4_out, o4_outn, o4_vld, o4_sat;
  logic [CH*4-1:0] o4_dat;

  jk_phase_detector #(.CHANNELS(CH), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .mode(mode), .j(j), .k(k),
    .out(o8_out), .out_n(o8_outn), .err_data(o8_dat), .err_valid(o8_vld), .err_sat(o8_sat)
  );

  jk_phase_detector #(.CHANNELS(CH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .j(j), .k(k),
    .out(o4_out), .out_n(o4_outn), .err_data(o4_dat), .err_valid(o4_vld), .err_sat(o4_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   ch;
    int   data;
    logic sat;
  } pub_t;

  pub_t q8[$];
  pub_t q4[$];

  // Behavioural reference: high length kept as an unbounded int, clipped only when published.
  logic q_m  [CH];
  int   len_m[CH];
  logic jd_m [CH];
  logic kd_m [CH];
  int   d8_m [CH];
  int   d4_m [CH];
  logic s8_m [CH];
  logic s4_m [CH];
  logic v_m  [CH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic m, input logic [CH-1:0] jv,
                            input logic [CH-1:0] kv);
    logic jx, kx, nq;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        q_m[c] = 0; len_m[c] = 0; jd_m[c] = 0; kd_m[c] = 0;
        d8_m[c] = 0; d4_m[c] = 0; s8_m[c] = 0; s4_m[c] = 0; v_m[c] = 0;
      end else begin
        jx = m ? (jv[c] & ~jd_m[c]) : jv[c];
        kx = m ? (kv[c] & ~kd_m[c]) : kv[c];
        nq = (jx & ~q_m[c]) | (~kx & q_m[c]);
        v_m[c] = 0;
        if (q_m[c] && !nq) begin
          v_m[c]  = 1;
          d8_m[c] = (len_m[c] > 255) ? 255 : len_m[c];
          s8_m[c] = (len_m[c] > 255);
          d4_m[c] = (len_m[c] > 15) ? 15 : len_m[c];
          s4_m[c] = (len_m[c] > 15);
          q8.push_back('{c, d8_m[c], s8_m[c]});
          q4.push_back('{c, d4_m[c], s4_m[c]});
        end
        len_m[c] = nq ? (q_m[c] ? len_m[c] + 1 : 1) : 0;
        jd_m[c]  = jv[c];
        kd_m[c]  = kv[c];
        q_m[c]   = nq;
      end
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0]   eo, eon, ev, es8, es4;
    logic [CH*8-1:0] ed8;
    logic [CH*4-1:0] ed4;
    pub_t e;
    for (int c = 0; c < CH; c++) begin
      eo[c] = q_m[c];
      ev[c] = v_m[c];
      es8[c] = s8_m[c];
      es4[c] = s4_m[c];
      ed8[c*8 +: 8] = d8_m[c][7:0];
      ed4[c*4 +: 4] = d4_m[c][3:0];
    end
    eon = ~eo;
    chk("out_w8", o8_out, eo);
    chk("outn_w8", o8_outn, eon);
    chk("vld_w8", o8_vld, ev);
    chk("data_w8", o8_dat, ed8);
    chk("sat_w8", o8_sat, es8);
    chk("out_w4", o4_out, eo);
    chk("outn_w4", o4_outn, eon);
    chk("vld_w4", o4_vld, ev);
    chk("data_w4", o4_dat, ed4);
    chk("sat_w4", o4_sat, es4);
    for (int c = 0; c < CH; c++) begin
      if (o8_vld[c]) begin
        if (q8.size() == 0) chk("sb8_unexpected", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          chk("sb8_ch", c, e.ch);
          chk("sb8_data", o8_dat[c*8 +: 8], e.data);
          chk("sb8_sat", o8_sat[c], e.sat);
        end
      end
      if (o4_vld[c]) begin
        if (q4.size() == 0) chk("sb4_unexpected", 64'd1, 64'd0);
        else begin
          e = q4.pop_front();
          chk("sb4_ch", c, e.ch);
          chk("sb4_data", o4_dat[c*4 +: 4], e.data);
          chk("sb4_sat", o4_sat[c], e.sat);
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic step(input logic r, input logic m, input logic [CH-1:0] jv,
                      input logic [CH-1:0] kv);
    reset = r; mode = m; j = jv; k = kv;
    @(posedge clk);
    model_edge(r, m, jv, kv);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct packed {
    logic          r;
    logic          m;
    logic [CH-1:0] jv;
    logic [CH-1:0] kv;
    logic [CH-1:0] eo;
    logic [CH-1:0] ev;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b1; mode = 1'b0; j = '0; k = '0;
    for (int c = 0; c < CH; c++) begin
      q_m[c] = 0; len_m[c] = 0; jd_m[c] = 0; kd_m[c] = 0;
      d8_m[c] = 0; d4_m[c] = 0; s8_m[c] = 0; s4_m[c] = 0; v_m[c] = 0;
    end

    // Reset with J=K=1, release, then toggles on channel 1.
    tbl[0] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[1] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0};
    tbl[4] = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 4'hF};
    tbl[5] = '{1'b0, 1'b0, 4'h2, 4'h2, 4'h2, 4'h0};
    tbl[6] = '{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 4'h2};
    tbl[7] = '{1'b0, 1'b0, 4'h2, 4'h2, 4'h2, 4'h0};
    tbl[8] = '{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 4'h2};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].m, tbl[i].jv, tbl[i].kv);
      chk("tbl_out", o8_out, tbl[i].eo);
      chk("tbl_vld", o8_vld, tbl[i].ev);
      if (tbl[i].r) chk("tbl_rst_data", o8_dat, 32'h0);
    end
    chk("tbl_ch1_data", o8_dat[15:8], 8'd1);

    // Level mode: 5-cycle pulse on channel 0.
    step(0, 0, 4'h1, 4'h0);
    repeat (4) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h1);
    chk("t2_vld", o8_vld, 4'h1);
    chk("t2_data", o8_dat[7:0], 8'd5);
    chk("t2_sat", o8_sat[0], 1'b0);
    step(0, 0, 4'h0, 4'h0);
    chk("t2_vld_once", o8_vld, 4'h0);
    chk("t2_hold", o8_dat[7:0], 8'd5);

    // Edge mode: held J must not re-set; simultaneous rises toggle.
    step(0, 1, 4'h4, 4'h0);
    chk("t4_set", o8_out[2], 1'b1);
    repeat (6) step(0, 1, 4'h4, 4'h0);
    step(0, 1, 4'h4, 4'h4);
    chk("t4_data", o8_dat[23:16], 8'd7);
    repeat (12) step(0, 1, 4'h4, 4'h4);
    chk("t4_no_reset", o8_out[2], 1'b0);
    step(0, 1, 4'h0, 4'h0);
    step(0, 1, 4'h4, 4'h4);
    chk("t4_toggle_up", o8_out[2], 1'b1);
    step(0, 1, 4'h0, 4'h0);
    step(0, 1, 4'h4, 4'h4);
    chk("t4_toggle_dn", o8_out[2], 1'b0);
    chk("t4_toggle_data", o8_dat[23:16], 8'd2);
    // Switching into edge mode with J already high must not produce an edge.
    step(0, 0, 4'h4, 4'h0);
    step(0, 1, 4'h4, 4'h0);
    step(0, 1, 4'h0, 4'h0);
    step(0, 1, 4'h0, 4'h4);
    chk("t4_modesw_data", o8_dat[23:16], 8'd3);
    step(0, 0, 4'h0, 4'h0);

    // Saturation on the 4-bit instance: 20 high cycles, then exactly 15, then 3.
    step(0, 0, 4'h8, 4'h0);
    repeat (19) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h8);
    chk("t5_data_w4", o4_dat[15:12], 4'd15);
    chk("t5_sat_w4", o4_sat[3], 1'b1);
    chk("t5_data_w8", o8_dat[31:24], 8'd20);
    chk("t5_sat_w8", o8_sat[3], 1'b0);
    step(0, 0, 4'h8, 4'h0);
    repeat (14) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h8);
    chk("t5_max_data", o4_dat[15:12], 4'd15);
    chk("t5_max_sat", o4_sat[3], 1'b0);
    step(0, 0, 4'h8, 4'h0);
    repeat (2) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h8);
    chk("t5_short_data", o4_dat[15:12], 4'd3);
    chk("t5_short_sat", o4_sat[3], 1'b0);

    // Reset mid-interval discards it; the next pulse publishes normally.
    step(0, 0, 4'h1, 4'h0);
    repeat (6) step(0, 0, 4'h0, 4'h0);
    step(1, 0, 4'h0, 4'h0);
    chk("t6_rst_out", o8_out[0], 1'b0);
    chk("t6_rst_vld", o8_vld, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    chk("t6_no_pub", o8_vld, 4'h0);
    step(0, 0, 4'h1, 4'h0);
    repeat (2) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h1);
    chk("t6_data", o8_dat[7:0], 8'd3);
    step(0, 0, 4'h0, 4'h0);

    chk("sb8_drained", q8.size(), 0);
    chk("sb4_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_phase_detector.md
Name: jk_phase_detector

Overview:
- Parametrised, multi-channel successor to the single JK flip-flop used as the DPLL phase detector.
- Each channel is a JK flip-flop with two selectable input modes:
  - level mode: classic JK behaviour.
  - edge mode: J/K act on rising edges only.
- Each channel also has a high-time counter. When a channel's output falls, the block publishes the number of cycles the output was high as a phase-error sample.
- Sits between the reference/DCO edge sources and the loop filter.

Parameters:
- CHANNELS, 4, number of independent detector channels.
- CNT_W, 16, width of each phase-error count; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = level mode, 1 = edge mode; shared by all channels.
- j  input  CHANNELS  per-channel J (reference edge source).
- k  input  CHANNELS  per-channel K (DCO edge source).
- out  output  CHANNELS  registered flip-flop state Q.
- out_n  output  CHANNELS  combinational ~out.
- err_data  output  CHANNELS*CNT_W  last published high-time per channel; channel c occupies bits [c*CNT_W +: CNT_W].
- err_valid  output  CHANNELS  one-cycle pulse per channel on each publish.
- err_sat  output  CHANNELS  high if the last published sample saturated.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - out=0, so out_n=all 1s.
  - err_data=0, err_valid=0, err_sat=0.
  - Edge history registers (j_d, k_d) = 0; high-time counters = 0.
- Effective inputs per channel:
  - Level mode: jx=j, kx=k.
  - Edge mode: jx = j & ~j_d, kx = k & ~k_d.
  - j_d/k_d register j/k every non-reset cycle in both modes, so a mode switch never produces a spurious edge.
  - A mode change takes effect on the first edge at which the new value is sampled.
- Next-state from {jx,kx}:
  - 00: hold.
  - 01: 0.
  - 10: 1.
  - 11: toggle.
- Latency:
  - j/k sampled at edge N are reflected on out after edge N (one register stage).
  - In edge mode, a rise of j between edges N-1 and N sets out after edge N.
- Counter cnt (CNT_W bits, per channel):
  - out=0 → cnt=0.
  - out=1 and next out=1 → cnt <= sat(cnt+1).
  - out=1 and next out=0 (falling) → publish sample, then cnt <= 0.
- Publish on a falling edge of out:
  - err_data <= sat(cnt+1), which equals the number of cycles out was high; a 1-cycle-high output gives 1.
  - err_sat <= 1 if cnt+1 would exceed 2^CNT_W-1, otherwise 0.
  - err_valid <= 1 for exactly one cycle.
  - err_data and err_sat hold until the next publish on that channel.
- Saturation: once cnt reaches max it holds at max and does not wrap.
- Simultaneous events:
  - jx=kx=1 while out=1 is a falling edge and publishes normally.
  - Fall and rise can never occur on the same edge.
  - Channels are fully independent; simultaneous publishes on several channels are all reported in the same cycle.
- Reset mid-operation: an in-progress high interval is discarded and no err_valid is produced.
- Widths:
  - All arithmetic is unsigned CNT_W bits.
  - Saturation is detected from the carry out of cnt+1, using a CNT_W+1-bit sum.

Decomposition:
- Shared package jk_pd_pkg:
  - Mode constants MODE_LEVEL=1'b0, MODE_EDGE=1'b1.
  - JK input encodings JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
- One sub-module jk_pd_channel holds a single channel: edge detect, JK state, counter and publish logic.
- The top level instantiates CHANNELS copies of it with a generate loop and packs err_data.

Test Plan:
1. Reset with all j=k held at all 1s for 3 cycles:
   - Required: out=0, out_n=4'b1111, err_valid=0, err_data=0 throughout.
   - After release in level mode: out[0] becomes 1 on the first edge.
2. Level mode, CNT_W=8; j[0]=1 for one cycle sampled at edge 10; k[0]=1 for one cycle sampled at edge 15:
   - Required: out[0] high for 5 cycles; err_valid[0] high for the single cycle after edge 15; err_data[0]=5; err_sat[0]=0.
   - Required: other channels unchanged.
3. Level mode, j[1]=k[1]=1 held for 4 edges:
   - Required: out[1] sequence 1,0,1,0; two err_valid[1] pulses, each with err_data[1]=1.
4. Edge mode; j[2] rises and stays high for 20 cycles; k[2] rises 7 edges later:
   - Required: out[2] high for exactly 7 cycles, err_data[2]=7; no re-set while j[2] is held high.
   - Simultaneous rise of j[2] and k[2] toggles out[2].
5. CNT_W=4, out[3] held high for 20 cycles, then k[3] pulsed:
   - Required: err_data[3]=15 and err_sat[3]=1.
   - A following 3-cycle pulse gives err_data[3]=3 and err_sat[3]=0.
6. Reset asserted while out[0]=1 with cnt=6:
   - Required: out[0]=0 after that edge and no err_valid pulse.
   - A subsequent 3-cycle pulse publishes err_data[0]=3.
